// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: walks an RGB LED around a 6-segment colour wheel.
// Only one channel ramps in each segment. The other two hold their level.
// A single free-running PWM counter drives all three LED outputs.
//
// state | meaning
// ------+-----------------------------------------
// S0    | green ramps 0->FULL, red=FULL, blue=0
// S1    | red ramps FULL->0, green=FULL, blue=0
// S2    | blue ramps 0->FULL, green=FULL, red=0
// S3    | green ramps FULL->0, blue=FULL, red=0
// S4    | red ramps 0->FULL, blue=FULL, green=0
// S5    | blue ramps FULL->0, red=FULL, green=0
module rgb_fade_sequencer #(
    parameter int STEP_INTERVAL = 12000,
    parameter int STEPS_PER_SEG = 200,
    parameter int PWM_INTERVAL  = 1200,
    parameter int STEP_VAL      = PWM_INTERVAL / STEPS_PER_SEG,
    localparam int FULL         = STEP_VAL * STEPS_PER_SEG,
    localparam int LVL_W        = $clog2(PWM_INTERVAL + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [LVL_W-1:0] red_level,
    output logic [LVL_W-1:0] green_level,
    output logic [LVL_W-1:0] blue_level,
    output logic [2:0]       seg_idx,
    output logic             seg_done,
    output logic             red_out,
    output logic             green_out,
    output logic             blue_out
);

    localparam int TICK_W = $clog2(STEP_INTERVAL + 1);
    localparam int STEP_W = $clog2(STEPS_PER_SEG + 1);

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} seg_t;

    seg_t              r_seg, w_seg_nxt;
    logic [LVL_W-1:0]  r_red, r_green, r_blue;
    logic [LVL_W-1:0]  w_red_nxt, w_green_nxt, w_blue_nxt;
    logic [TICK_W-1:0] r_tick;
    logic [STEP_W-1:0] r_step;
    logic [LVL_W-1:0]  r_pwm_cnt;
    logic              r_seg_done;
    logic              r_red_out, r_green_out, r_blue_out;
    logic              w_step;
    logic              w_last;

    assign w_step = enable && (r_tick == TICK_W'(STEP_INTERVAL - 1));
    assign w_last = (r_step == STEP_W'(STEPS_PER_SEG - 1));

    // Saturate at FULL so a level can never wrap, and land exactly on FULL at segment end.
    function automatic logic [LVL_W-1:0] ramp_up(input logic [LVL_W-1:0] lvl, input logic last);
        if (last || (lvl >= LVL_W'(FULL - STEP_VAL)))
            return LVL_W'(FULL);
        return lvl + LVL_W'(STEP_VAL);
    endfunction

    // Saturate at 0 so a level can never wrap, and land exactly on 0 at segment end.
    function automatic logic [LVL_W-1:0] ramp_dn(input logic [LVL_W-1:0] lvl, input logic last);
        if (last || (lvl <= LVL_W'(STEP_VAL)))
            return '0;
        return lvl - LVL_W'(STEP_VAL);
    endfunction

    // Next segment and next levels. Only the ramping channel of the current segment moves.
    always_comb begin
        w_seg_nxt   = r_seg;
        w_red_nxt   = r_red;
        w_green_nxt = r_green;
        w_blue_nxt  = r_blue;
        if (w_step) begin
            case (r_seg)
                S0: w_green_nxt = ramp_up(r_green, w_last);
                S1: w_red_nxt   = ramp_dn(r_red,   w_last);
                S2: w_blue_nxt  = ramp_up(r_blue,  w_last);
                S3: w_green_nxt = ramp_dn(r_green, w_last);
                S4: w_red_nxt   = ramp_up(r_red,   w_last);
                S5: w_blue_nxt  = ramp_dn(r_blue,  w_last);
                default: ;
            endcase
            if (w_last) begin
                case (r_seg)
                    S0: w_seg_nxt = S1;
                    S1: w_seg_nxt = S2;
                    S2: w_seg_nxt = S3;
                    S3: w_seg_nxt = S4;
                    S4: w_seg_nxt = S5;
                    default: w_seg_nxt = S0;
                endcase
            end
        end
    end

    // Segment state, levels and the segment-advance pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg      <= S0;
            r_red      <= LVL_W'(FULL);
            r_green    <= '0;
            r_blue     <= '0;
            r_seg_done <= 1'b0;
        end else begin
            r_seg      <= w_seg_nxt;
            r_red      <= w_red_nxt;
            r_green    <= w_green_nxt;
            r_blue     <= w_blue_nxt;
            r_seg_done <= w_step && w_last;
        end
    end

    // Step timer and per-segment step counter. Both hold while enable is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick <= '0;
            r_step <= '0;
        end else if (enable) begin
            if (w_step) begin
                r_tick <= '0;
                r_step <= w_last ? '0 : r_step + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    // PWM keeps running when enable is low, so a frozen colour stays lit.
    // Each output is registered from the compare, which adds one cycle of latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt   <= '0;
            r_red_out   <= 1'b0;
            r_green_out <= 1'b0;
            r_blue_out  <= 1'b0;
        end else begin
            r_pwm_cnt   <= (r_pwm_cnt == LVL_W'(PWM_INTERVAL - 1)) ? '0 : r_pwm_cnt + 1'b1;
            r_red_out   <= r_pwm_cnt < r_red;
            r_green_out <= r_pwm_cnt < r_green;
            r_blue_out  <= r_pwm_cnt < r_blue;
        end
    end

    assign red_level   = r_red;
    assign green_level = r_green;
    assign blue_level  = r_blue;
    assign seg_idx     = r_seg;
    assign seg_done    = r_seg_done;
    assign red_out     = r_red_out;
    assign green_out   = r_green_out;
    assign blue_out    = r_blue_out;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer with a small configuration
// (4 clk per step, 4 steps per segment, PWM period 8, FULL = 8).
module tb_rgb_fade_sequencer;

    localparam int FULL = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] red_level, green_level, blue_level;
    logic [2:0] seg_idx;
    logic       seg_done, red_out, green_out, blue_out;

    rgb_fade_sequencer #(
        .STEP_INTERVAL(4),
        .STEPS_PER_SEG(4),
        .PWM_INTERVAL (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .red_level  (red_level),
        .green_level(green_level),
        .blue_level (blue_level),
        .seg_idx    (seg_idx),
        .seg_done   (seg_done),
        .red_out    (red_out),
        .green_out  (green_out),
        .blue_out   (blue_out)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {SEL_R, SEL_G, SEL_B, SEL_SEG, SEL_DONE, SEL_ROUT, SEL_GOUT, SEL_BOUT} sel_t;
    typedef struct {
        int    cyc;
        sel_t  sel;
        int    val;
        string name;
    } exp_t;
    typedef struct {
        int seg;
        int r;
        int g;
        int b;
    } seg_rec_t;

    exp_t     exp_q[$];
    seg_rec_t done_q[$];
    int       n_assert = 0;
    int       n_fail   = 0;
    int       n_pulses = 0;

    task automatic check(input string nm, input int act, input int exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
        end
    endtask

    task automatic expect_at(input int c, input sel_t s, input int v, input string nm);
        exp_q.push_back('{c, s, v, nm});
    endtask

    task automatic expect_lvl(input int c, input int r, input int g, input int b, input int seg);
        expect_at(c, SEL_R,   r,   "red_level");
        expect_at(c, SEL_G,   g,   "green_level");
        expect_at(c, SEL_B,   b,   "blue_level");
        expect_at(c, SEL_SEG, seg, "seg_idx");
    endtask

    task automatic expect_seg_end(input int seg, input int r, input int g, input int b);
        done_q.push_back('{seg, r, g, b});
    endtask

    function automatic int read_sel(input sel_t s);
        case (s)
            SEL_R:    return int'(red_level);
            SEL_G:    return int'(green_level);
            SEL_B:    return int'(blue_level);
            SEL_SEG:  return int'(seg_idx);
            SEL_DONE: return int'(seg_done);
            SEL_ROUT: return int'(red_out);
            SEL_GOUT: return int'(green_out);
            default:  return int'(blue_out);
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: on each falling edge, compare time-tagged expectations, range-check
    // the levels, and pop one segment record per seg_done pulse.
    initial begin
        seg_rec_t rec;
        forever begin
            @(negedge clk);
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc == cyc) begin
                    check(exp_q[i].name, read_sel(exp_q[i].sel), exp_q[i].val);
                    exp_q.delete(i);
                end
            end
            if (cyc >= 1) begin
                check("red_in_range",   int'(red_level   <= 4'(FULL)), 1);
                check("green_in_range", int'(green_level <= 4'(FULL)), 1);
                check("blue_in_range",  int'(blue_level  <= 4'(FULL)), 1);
            end
            if (seg_done === 1'b1) begin
                n_pulses++;
                if (done_q.size() == 0) begin
                    check("unexpected_seg_done", 1, 0);
                end else begin
                    rec = done_q.pop_front();
                    check("seg_end_idx",   int'(seg_idx),     rec.seg);
                    check("seg_end_red",   int'(red_level),   rec.r);
                    check("seg_end_green", int'(green_level), rec.g);
                    check("seg_end_blue",  int'(blue_level),  rec.b);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;

        // Reset values, first ramp steps and PWM with G=2 frozen.
        for (int c = 1; c <= 3; c++) begin
            expect_lvl(c, 8, 0, 0, 0);
            expect_at(c, SEL_DONE, 0, "seg_done_reset");
            expect_at(c, SEL_ROUT, 0, "red_out_reset");
            expect_at(c, SEL_GOUT, 0, "green_out_reset");
            expect_at(c, SEL_BOUT, 0, "blue_out_reset");
        end
        for (int c = 4; c <= 6; c++) expect_lvl(c, 8, 0, 0, 0);
        expect_at(7, SEL_G, 2, "green_first_step");
        for (int c = 8; c <= 24; c++) begin
            expect_at(c, SEL_GOUT, int'(((c - 4) % 8) < 2), "green_out_pwm");
            expect_at(c, SEL_ROUT, 1, "red_out_full");
            expect_at(c, SEL_BOUT, 0, "blue_out_zero");
        end
        expect_lvl(24, 8, 2, 0, 0);
        expect_at(26, SEL_G, 2, "green_hold_after_freeze");
        expect_at(27, SEL_G, 4, "green_step2");
        expect_at(31, SEL_G, 6, "green_step3");
        expect_lvl(34, 8, 6, 0, 0);
        expect_at(34, SEL_DONE, 0, "seg_done_before_end");
        expect_at(35, SEL_DONE, 1, "seg_done_pulse");
        expect_at(36, SEL_DONE, 0, "seg_done_one_cycle");

        wait_cyc(3);
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_cyc(8);
        enable = 1'b0;
        wait_cyc(24);
        enable = 1'b1;

        // Full wheel, then the wrap back to S0.
        expect_seg_end(1, 8, 8, 0);
        expect_seg_end(2, 0, 8, 0);
        expect_seg_end(3, 0, 8, 8);
        expect_seg_end(4, 0, 0, 8);
        expect_seg_end(5, 8, 0, 8);
        expect_seg_end(0, 8, 0, 0);
        expect_lvl(39,  6, 8, 0, 1);
        expect_lvl(55,  0, 8, 2, 2);
        expect_lvl(71,  0, 6, 8, 3);
        expect_lvl(87,  2, 0, 8, 4);
        expect_lvl(103, 8, 0, 6, 5);
        expect_lvl(115, 8, 0, 0, 0);
        wait_cyc(115);

        // Second pass: pause in S2 with tick_cnt=2, then ramp into S3.
        expect_seg_end(1, 8, 8, 0);
        expect_seg_end(2, 0, 8, 0);
        expect_seg_end(3, 0, 8, 8);
        expect_lvl(155, 0, 8, 0, 2);
        expect_lvl(159, 0, 8, 0, 2);
        expect_at(160, SEL_B, 0, "blue_hold_after_resume");
        expect_at(161, SEL_B, 2, "blue_step_after_resume");
        expect_lvl(177, 0, 6, 8, 3);
        expect_lvl(184, 0, 4, 8, 3);
        wait_cyc(149);
        enable = 1'b0;
        wait_cyc(159);
        enable = 1'b1;
        wait_cyc(184);

        // One-cycle reset on the edge that would otherwise be a step.
        expect_lvl(185, 8, 0, 0, 0);
        expect_at(185, SEL_DONE, 0, "seg_done_at_reset");
        expect_at(185, SEL_ROUT, 0, "red_out_at_reset");
        expect_at(186, SEL_DONE, 0, "seg_done_after_reset");
        expect_at(186, SEL_ROUT, 1, "red_out_after_reset");
        expect_at(186, SEL_GOUT, 0, "green_out_after_reset");
        expect_at(188, SEL_G, 0, "green_before_first_step");
        expect_at(189, SEL_G, 2, "green_first_step_after_reset");
        rst_n = 1'b0;
        wait_cyc(185);
        rst_n = 1'b1;
        wait_cyc(192);

        check("seg_done_pulse_count", n_pulses, 9);
        check("pending_expectations", exp_q.size(), 0);
        check("pending_seg_ends", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Sequences three PWM fade channels (red, green, blue) around a 6-segment colour wheel; exactly one channel ramps per segment while the other two hold.
- Owns the step timer, the ramp counters, the segment state machine and a shared free-running PWM generator, and drives the three LED enables directly.
- Sits between the board clock and the RGB LED pins, and replaces per-channel stand-alone fade timing.

Parameters:
- STEP_INTERVAL, 12000: clk cycles per ramp step (1 ms at 12 MHz).
- STEPS_PER_SEG, 200: ramp steps per segment.
- PWM_INTERVAL, 1200: PWM period in clk cycles (100 us).
- STEP_VAL, PWM_INTERVAL/STEPS_PER_SEG: level change per step.
- Derived: FULL = STEP_VAL*STEPS_PER_SEG; LVL_W = $clog2(PWM_INTERVAL+1).
- Legal configurations require PWM_INTERVAL % STEPS_PER_SEG == 0, so FULL == PWM_INTERVAL.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  1 = step timer and ramps advance; 0 = freeze (PWM keeps running).
- red_level  output  LVL_W  current red duty (0..FULL).
- green_level  output  LVL_W  current green duty.
- blue_level  output  LVL_W  current blue duty.
- seg_idx  output  3  current segment 0..5.
- seg_done  output  1  one-cycle pulse on segment advance.
- red_out  output  1  red PWM drive, active-high.
- green_out  output  1  green PWM drive, active-high.
- blue_out  output  1  blue PWM drive, active-high.

Behaviour:
- Reset: all registers are sampled on posedge clk while rst_n=0. Reset values: seg_idx=0, red_level=FULL, green_level=0, blue_level=0, seg_done=0, red_out=green_out=blue_out=0, tick_cnt=0, step_cnt=0, pwm_cnt=0.
- Reset mid-operation restores all of the above on the next edge, overriding any pending step.
- Segment table (ramping channel, others hold):
  - S0: G 0->FULL, R=FULL, B=0.
  - S1: R FULL->0, G=FULL, B=0.
  - S2: B 0->FULL, G=FULL, R=0.
  - S3: G FULL->0, B=FULL, R=0.
  - S4: R 0->FULL, B=FULL, G=0.
  - S5: B FULL->0, R=FULL, G=0.
  - S5 advances to S0 (wrap).
- Step timer: tick_cnt counts 0..STEP_INTERVAL-1 while enable=1 and holds while enable=0. A step event fires on the edge where tick_cnt==STEP_INTERVAL-1 and enable=1; tick_cnt wraps to 0 on that same edge.
- The first step event after reset is the STEP_INTERVAL-th enabled cycle.
- On a step event:
  - The ramping channel moves +/-STEP_VAL and step_cnt increments.
  - If step_cnt==STEPS_PER_SEG-1: the ramping channel is forced to exactly FULL (up) or 0 (down), step_cnt goes to 0, seg_idx advances, and seg_done=1 for exactly that one following cycle.
- Levels never leave 0..FULL. No underflow or overflow wrap is permitted.
- enable deasserted mid-segment: levels, seg_idx, tick_cnt and step_cnt all hold; when enable reasserts, counting resumes from the held tick_cnt.
- PWM generator:
  - pwm_cnt free-runs 0..PWM_INTERVAL-1 regardless of enable.
  - Each x_out is registered as (pwm_cnt < x_level), giving 1-cycle latency.
  - Level 0 means the output is always low; level FULL means always high.
  - Levels updated mid-period take effect at the next compare (no period-boundary latching).

Test Plan (STEP_INTERVAL=4, STEPS_PER_SEG=4, PWM_INTERVAL=8, so STEP_VAL=2, FULL=8):
- Reset hold 3 cycles, release, enable=1 -> levels R=8/G=0/B=0 and seg_idx=0 until cycle 4; at cycle 4 G=2; at cycles 8, 12, 16 G=4, 6, 8; at cycle 16 seg_idx=1 and seg_done high for 1 cycle only.
- Run 24 step events (6 segments) -> seg_idx sequence 0,1,2,3,4,5,0; levels after the wrap are R=8/G=0/B=0; exactly 6 seg_done pulses.
- enable=0 for 10 cycles at tick_cnt=2 in S2 -> levels and seg_idx unchanged; after re-enable, the next step occurs 2 enabled cycles later.
- PWM check with G=2 -> green_out high for exactly 2 of every 8 cycles, lagging pwm_cnt by 1 cycle; R=8 -> red_out constantly high; B=0 -> blue_out constantly low.
- rst_n=0 for 1 cycle in S3 mid-ramp, coinciding with a step event -> next state is S0 reset values and no seg_done pulse; the first step lands 4 cycles after release.
- Boundary check: every level sampled across a full wheel stays within 0..8; each ramp endpoint equals exactly 0 or 8.
